// File: rtl/haraka_round_ctrl_if.sv
// rtl/haraka_round_ctrl_if.sv - message, datapath and digest signals of the Haraka round controller
interface haraka_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] msg_in;
    logic [511:0] dp_in;
    logic [511:0] dp_result;
    logic         dp_encrypt;
    logic [3:0]   dp_rc_idx;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] digest;
    logic         busy;

    modport slave (
        input  in_valid, msg_in, dp_result, out_ready,
        output in_ready, dp_in, dp_encrypt, dp_rc_idx, out_valid, digest, busy
    );

    modport master (
        output in_valid, msg_in, dp_result, out_ready,
        input  in_ready, dp_in, dp_encrypt, dp_rc_idx, out_valid, digest, busy
    );
endinterface

// File: rtl/haraka_round_ctrl.sv
// rtl/haraka_round_ctrl.sv - Haraka permutation round sequencer; HARAKA_FEEDFORWARD_EN adds the XOR feed-forward
module haraka_round_ctrl #(
    parameter int NROUNDS      = 5,
    parameter int ROUND_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    haraka_round_ctrl_if.slave bus
);
    localparam logic [3:0] LAST_R = 4'(NROUNDS - 1);
    localparam logic [3:0] LAST_C = 4'(ROUND_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [3:0]   r_q, r_d;
    logic [3:0]   c_q, c_d;
    logic [511:0] st_q, st_d;
    logic [511:0] f;
    logic         rdy_q;
    logic         in_ready_c;
    logic         accept;
`ifdef HARAKA_FEEDFORWARD_EN
    logic [511:0] msg_q, msg_d;
`endif

    // rdy_q keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            st_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            st_q    <= st_d;
            rdy_q   <= 1'b1;
        end
    end

`ifdef HARAKA_FEEDFORWARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_q <= '0;
        end else begin
            msg_q <= msg_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        st_d       = st_q;
        in_ready_c = 1'b0;
        accept     = 1'b0;
`ifdef HARAKA_FEEDFORWARD_EN
        msg_d      = msg_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready_c = rdy_q;
            end
            RUN: begin
                if (c_q == LAST_C) begin
                    st_d = bus.dp_result;
                    c_d  = '0;
                    r_d  = r_q + 4'd1;
                    if (r_q == LAST_R) begin
                        state_d = DONE;
                    end
                end else begin
                    c_d = c_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    in_ready_c = rdy_q;
                    if (!bus.in_valid) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new message may replace a drained digest in the same cycle
        accept = bus.in_valid & in_ready_c;
        if (accept) begin
            state_d = RUN;
            st_d    = bus.msg_in;
            r_d     = '0;
            c_d     = '0;
`ifdef HARAKA_FEEDFORWARD_EN
            msg_d   = bus.msg_in;
`endif
        end
    end

`ifdef HARAKA_FEEDFORWARD_EN
    assign f = st_q ^ msg_q;
`else
    assign f = st_q;
`endif

    assign bus.in_ready   = in_ready_c;
    assign bus.dp_in      = st_q;
    assign bus.dp_encrypt = (state_q == RUN);
    assign bus.dp_rc_idx  = (state_q == RUN) ? r_q : 4'd0;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.digest     = {f[479:416], f[351:288], f[223:160], f[95:32]};
endmodule

// File: tb/tb_haraka_round_ctrl.sv
// tb/tb_haraka_round_ctrl.sv - scoreboard bench for haraka_round_ctrl with a rotate-by-32 datapath stub
module tb_haraka_round_ctrl;
    localparam int NR = 5;
    localparam int RC = 2;

    typedef struct {
        logic [255:0] dig;
        int           acc;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rand_mode = 1'b0;
    bit   prev_ov = 1'b0;
    exp_t sb[$];

    haraka_round_ctrl_if bus();

    haraka_round_ctrl #(.NROUNDS(NR), .ROUND_CYCLES(RC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.dp_result = {bus.dp_in[479:0], bus.dp_in[511:480]};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] model(input logic [511:0] m);
        logic [511:0] s;
        logic [511:0] f;
        logic [255:0] d;
        int sh;
        sh = (32 * NR) % 512;
        s  = (sh == 0) ? m : ((m << sh) | (m >> (512 - sh)));
`ifdef HARAKA_FEEDFORWARD_EN
        f = s ^ m;
`else
        f = s;
`endif
        for (int k = 0; k < 4; k++) d[64*k +: 64] = f[128*k + 32 +: 64];
        return d;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_msg();
        logic [511:0] m;
        for (int k = 0; k < 16; k++) m[32*k +: 32] = $urandom;
        return m;
    endfunction

    // Stimulus recorder: every accepted message gets its expected digest and deadline
    always begin
        @(negedge clk);
        #1;
        if (rst_n && bus.in_valid && bus.in_ready)
            sb.push_back('{dig: model(bus.msg_in), acc: cyc + 1, due: cyc + 1 + NR * RC});
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.dp_encrypt) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL run_without_message cyc=%0d", cyc);
                end else begin
                    chk("rc_idx", 256'(bus.dp_rc_idx), 256'((cyc - sb[$].acc) / RC));
                end
            end
            if (bus.out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out_valid cyc=%0d", cyc);
                end else begin
                    chk("out_valid_latency", 256'(cyc), 256'(sb[0].due));
                end
            end
            if (bus.out_valid && sb.size() != 0) begin
                chk("digest", bus.digest, sb[0].dig);
                if (!bus.out_ready) begin
                    chk("stall_in_ready", 256'(bus.in_ready), 256'(0));
                    chk("stall_busy", 256'(bus.busy), 256'(1));
                end else begin
                    void'(sb.pop_front());
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic send(input logic [511:0] m);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.msg_in   = m;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
            if (!ok && rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout act=0 exp=1");
        end
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (bus.out_valid) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL out_valid_timeout act=0 exp=1");
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            if (sb.size() == 0 && !bus.busy) ok = 1'b1;
            else begin
                tick();
                if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending=%0d", sb.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [511:0] m;
        bus.in_valid  = 1'b0;
        bus.msg_in    = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_in_ready",   256'(bus.in_ready),   256'(0));
        chk("reset_out_valid",  256'(bus.out_valid),  256'(0));
        chk("reset_busy",       256'(bus.busy),       256'(0));
        chk("reset_dp_encrypt", 256'(bus.dp_encrypt), 256'(0));
        chk("reset_rc_idx",     256'(bus.dp_rc_idx),  256'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("in_ready_after_reset", 256'(bus.in_ready), 256'(1));

        // Single-bit message: five 32-bit rotations land bit 0 on digest bit 64
        send(512'h1);
        wait_valid();
        chk("digest_msg1", bus.digest, 256'h1 << 64);
        drain();

        m = 512'h1 << 32;
        send(m);
        drain();

        // Digest held while the sink stalls
        bus.out_ready = 1'b0;
        send(rand_msg());
        wait_valid();
        repeat (7) tick();
        chk("stall_out_valid", 256'(bus.out_valid), 256'(1));
        bus.out_ready = 1'b1;
        drain();

        // Back-to-back: release and new message in the same DONE cycle
        bus.out_ready = 1'b0;
        send(rand_msg());
        wait_valid();
        repeat (2) tick();
        bus.out_ready = 1'b1;
        send(rand_msg());
        chk("b2b_busy", 256'(bus.busy), 256'(1));
        drain();

        // in_valid pulsed mid-run must be ignored
        send(rand_msg());
        repeat (3) tick();
        bus.in_valid = 1'b1;
        bus.msg_in   = rand_msg();
        tick();
        bus.in_valid = 1'b0;
        drain();

        // Reset during the fourth RUN cycle abandons the message
        send(rand_msg());
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrun_reset_out_valid",  256'(bus.out_valid),  256'(0));
        chk("midrun_reset_busy",       256'(bus.busy),       256'(0));
        chk("midrun_reset_dp_encrypt", 256'(bus.dp_encrypt), 256'(0));
        chk("midrun_reset_in_ready",   256'(bus.in_ready),   256'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (20) tick();
        chk("midrun_reset_no_digest", 256'(bus.out_valid), 256'(0));
        send(rand_msg());
        drain();

        // Randomized traffic with a randomly stalling sink
        rand_mode = 1'b1;
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 3)) begin
                tick();
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            send(rand_msg());
        end
        drain();
        rand_mode     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("final_idle", 256'(bus.busy), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
